// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO widths, arbiter FSM states and the forced read value used on a watchdog timeout.
package mdio_pkg;
    localparam int MDIO_ADDR_W = 5;
    localparam int MDIO_DATA_W = 16;
    localparam logic [MDIO_DATA_W-1:0] MDIO_TO_RD_DATA = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
endpackage

// File: rtl/mdio_rr_pick.sv
// mdio_rr_pick: combinational round-robin winner select with optional fixed priority for requester 0.
//   req        : per-requester valid vector
//   last_grant : index granted most recently; the scan starts just above it
//   prio0      : 1 = requester 0 wins whenever it is valid
//   grant      : winning index (meaningful only when any = 1)
//   any        : at least one request is valid
module mdio_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    input  logic               prio0,
    output logic [GW-1:0]      grant,
    output logic               any
);
    // Scan from farthest to nearest so the first set bit after last_grant is the last one written.
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last_grant) + k) % NUM_REQ]) grant = GW'((int'(last_grant) + k) % NUM_REQ);
        if (prio0 && req[0]) grant = '0;
    end
    assign any = |req;
endmodule

// File: rtl/mdio_arb.sv
// mdio_arb: shares one MDIO operation interface between NUM_REQ requesters, one operation at a time,
// with a watchdog that forces completion when the driver never answers.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/rh_wl/addr/wr_data       : packed per-requester requests
//   req_ready                          : one-hot accept pulse
//   rsp_done/rd_data/rd_ack/timeout    : one-hot completion pulse and its result
//   busy                               : an operation is outstanding
//   op_exec/rh_wl/addr/wr_data         : start pulse and fields to the MDIO driver
//   op_done/rd_data/rd_ack             : completion from the MDIO driver
module mdio_arb
    import mdio_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter bit PRIO0       = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_rh_wl,
    input  logic [NUM_REQ*MDIO_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*MDIO_DATA_W-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_done,
    output logic [MDIO_DATA_W-1:0]           rsp_rd_data,
    output logic                             rsp_rd_ack,
    output logic                             rsp_timeout,
    output logic                             busy,
    output logic                             op_exec,
    output logic                             op_rh_wl,
    output logic [MDIO_ADDR_W-1:0]           op_addr,
    output logic [MDIO_DATA_W-1:0]           op_wr_data,
    input  logic                             op_done,
    input  logic [MDIO_DATA_W-1:0]           op_rd_data,
    input  logic                             op_rd_ack
);
    localparam int GW = NUM_REQ > 2 ? 2 : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    state_t          state, state_nx;
    logic [GW-1:0]   last_grant, cur, g;
    logic [CW-1:0]   cnt;
    logic            any, expire;
    mdio_rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .prio0      (PRIO0),
        .grant      (g),
        .any        (any)
    );
    assign expire = cnt == CW'(TIMEOUT_CYC - 1);
    assign busy   = state != IDLE;
    always_comb begin
        state_nx = state == IDLE ? (any ? WAIT : IDLE) :
                   state == WAIT ? (op_done || expire ? GAP : WAIT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= GW'(NUM_REQ - 1);
            cur         <= '0;
            cnt         <= '0;
            req_ready   <= '0;
            rsp_done    <= '0;
            rsp_rd_data <= '0;
            rsp_rd_ack  <= 1'b0;
            rsp_timeout <= 1'b0;
            op_exec     <= 1'b0;
            op_rh_wl    <= 1'b0;
            op_addr     <= '0;
            op_wr_data  <= '0;
        end else begin
            op_exec   <= 1'b0;
            req_ready <= '0;
            rsp_done  <= '0;
            if (state == IDLE && any) begin
                op_exec      <= 1'b1;
                op_rh_wl     <= req_rh_wl[g];
                op_addr      <= req_addr[MDIO_ADDR_W*g +: MDIO_ADDR_W];
                op_wr_data   <= req_wr_data[MDIO_DATA_W*g +: MDIO_DATA_W];
                req_ready[g] <= 1'b1;
                cur          <= g;
                cnt          <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                // op_done takes precedence over a watchdog expiry on the same cycle.
                if (op_done || expire) begin
                    rsp_done[cur] <= 1'b1;
                    rsp_rd_data   <= op_done ? op_rd_data : MDIO_TO_RD_DATA;
                    rsp_rd_ack    <= op_done ? op_rd_ack : 1'b1;
                    rsp_timeout   <= !op_done;
                    last_grant    <= cur;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdio_arb.sv
// tb_mdio_arb: scoreboard bench for mdio_arb with a driver model and a PRIO0 instance.
module tb_mdio_arb;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_rh_wl = '0, req_ready, rsp_done;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wr_data = '0;
    logic [15:0] rsp_rd_data, op_wr_data, op_rd_data = '0;
    logic        rsp_rd_ack, rsp_timeout, busy, op_exec, op_rh_wl, op_done = 1'b0, op_rd_ack = 1'b0;
    logic [4:0]  op_addr;
    logic [1:0]  p_req_valid = '0, p_req_ready, p_rsp_done;
    logic [15:0] p_rsp_rd_data, p_op_wr_data;
    logic        p_rsp_rd_ack, p_rsp_timeout, p_busy, p_op_exec, p_op_rh_wl, p_op_done = 1'b0;
    logic [4:0]  p_op_addr;
    logic [45:0] outs;
    int n_checks = 0, n_err = 0, cyc = 0, exec_cyc = 0, g0 = 0, g1 = 0;

    typedef struct {logic rh; logic [4:0] a; logic [15:0] wd;} rq_t;
    typedef struct {logic [1:0] ready; logic rh; logic [4:0] a; logic [15:0] wd;} eop_t;
    typedef struct {int lat; logic [15:0] rd; logic ack;} drv_t;
    typedef struct {logic [1:0] done; logic [15:0] rd; logic ack; logic to; int dly;} ersp_t;
    rq_t   rq0[$], rq1[$];
    eop_t  exp_op[$];
    drv_t  drv[$];
    ersp_t exp_rsp[$];

    mdio_arb #(.NUM_REQ(2), .TIMEOUT_CYC(TO), .PRIO0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rh_wl(req_rh_wl), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_ready(req_ready), .rsp_done(rsp_done), .rsp_rd_data(rsp_rd_data),
        .rsp_rd_ack(rsp_rd_ack), .rsp_timeout(rsp_timeout), .busy(busy), .op_exec(op_exec),
        .op_rh_wl(op_rh_wl), .op_addr(op_addr), .op_wr_data(op_wr_data), .op_done(op_done),
        .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack)
    );
    mdio_arb #(.NUM_REQ(2), .TIMEOUT_CYC(TO), .PRIO0(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .req_valid(p_req_valid), .req_rh_wl(2'b11), .req_addr(10'd0),
        .req_wr_data(32'd0), .req_ready(p_req_ready), .rsp_done(p_rsp_done), .rsp_rd_data(p_rsp_rd_data),
        .rsp_rd_ack(p_rsp_rd_ack), .rsp_timeout(p_rsp_timeout), .busy(p_busy), .op_exec(p_op_exec),
        .op_rh_wl(p_op_rh_wl), .op_addr(p_op_addr), .op_wr_data(p_op_wr_data), .op_done(p_op_done),
        .op_rd_data(16'h0000), .op_rd_ack(1'b0)
    );
    assign outs = {req_ready, rsp_done, rsp_rd_data, rsp_rd_ack, rsp_timeout, busy,
                   op_exec, op_rh_wl, op_addr, op_wr_data};

    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic add(input int r, input logic rh, input logic [4:0] a, input logic [15:0] wd,
                       input int lat, input logic [15:0] rd, input logic ack, input bit abort);
        rq_t   q;
        eop_t  e;
        drv_t  d;
        ersp_t s;
        q = '{rh, a, wd};
        if (r == 0) rq0.push_back(q); else rq1.push_back(q);
        e = '{2'(1 << r), rh, a, wd};
        exp_op.push_back(e);
        d = '{lat, rd, ack};
        drv.push_back(d);
        if (lat < 0 || lat > TO - 1) s = '{2'(1 << r), 16'hFFFF, 1'b1, 1'b1, TO};
        else                         s = '{2'(1 << r), rd, ack, 1'b0, lat + 1};
        if (!abort) exp_rsp.push_back(s);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_op.size() || exp_rsp.size() || rq0.size() || rq1.size()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(exp_op.size() + exp_rsp.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Requesters: present the head of each queue, retire it on req_ready.
    initial forever begin
        @(negedge clk);
        if (req_ready[0] && rq0.size()) void'(rq0.pop_front());
        if (req_ready[1] && rq1.size()) void'(rq1.pop_front());
        req_valid[0] = rq0.size() != 0;
        req_valid[1] = rq1.size() != 0;
        if (rq0.size()) begin req_rh_wl[0] = rq0[0].rh; req_addr[4:0] = rq0[0].a; req_wr_data[15:0] = rq0[0].wd; end
        if (rq1.size()) begin req_rh_wl[1] = rq1[0].rh; req_addr[9:5] = rq1[0].a; req_wr_data[31:16] = rq1[0].wd; end
    end

    // MDIO driver model: answers each op_exec after lat cycles (lat < 0 = never).
    initial forever begin
        drv_t d;
        @(negedge clk);
        if (op_exec) begin
            d = drv.size() ? drv.pop_front() : '{-1, 16'h0, 1'b0};
            if (d.lat >= 0) begin
                repeat (d.lat) @(negedge clk);
                op_done = 1'b1; op_rd_data = d.rd; op_rd_ack = d.ack;
                @(negedge clk);
                op_done = 1'b0;
            end
        end
    end

    // Monitor: compare every accept and every completion against the scoreboard.
    initial forever begin
        eop_t  e;
        ersp_t s;
        @(negedge clk);
        if (op_exec) exec_cyc = cyc;
        if (req_ready != 0 || op_exec) begin
            if (exp_op.size() == 0) chk("unexpected_grant", 64'({req_ready, op_exec}), 64'd0);
            else begin
                e = exp_op.pop_front();
                chk("grant", 64'(req_ready), 64'(e.ready));
                chk("op_exec", 64'(op_exec), 64'd1);
                chk("op_fields", 64'({op_rh_wl, op_addr, op_wr_data}), 64'({e.rh, e.a, e.wd}));
            end
        end
        if (rsp_done != 0) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(rsp_done), 64'd0);
            else begin
                s = exp_rsp.pop_front();
                chk("rsp_done", 64'(rsp_done), 64'(s.done));
                chk("rsp_rd_data", 64'(rsp_rd_data), 64'(s.rd));
                chk("rsp_rd_ack", 64'(rsp_rd_ack), 64'(s.ack));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(s.to));
                chk("rsp_latency", 64'(cyc - exec_cyc), 64'(s.dly));
            end
        end
    end

    // PRIO0 instance: driver answers two cycles after op_exec; count grants per requester.
    initial forever begin
        @(negedge clk);
        p_op_done = 1'b0;
        if (p_op_exec) begin
            repeat (2) @(negedge clk);
            p_op_done = 1'b1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (p_req_ready[0]) g0++;
        if (p_req_ready[1]) g1++;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(outs), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Simultaneous requests from reset: alternate 0,1,0,1.
        @(posedge clk);
        add(0, 1'b1, 5'h01, 16'h0000, 3, 16'h1234, 1'b0, 0);
        add(1, 1'b1, 5'h11, 16'h0000, 3, 16'h5678, 1'b1, 0);
        add(0, 1'b1, 5'h01, 16'h0000, 4, 16'h00A5, 1'b0, 0);
        add(1, 1'b1, 5'h11, 16'h0000, 2, 16'hC3C3, 1'b0, 0);
        wait_idle(200);
        // Single write with one-cycle accept latency.
        @(posedge clk);
        add(0, 1'b0, 5'h00, 16'h9140, 12, 16'h0000, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("exec_latency", 64'({op_exec, req_ready}), 64'b101);
        wait_idle(100);
        // Read data routed to requester 1.
        @(posedge clk);
        add(1, 1'b1, 5'h01, 16'h0000, 5, 16'h8000, 1'b0, 0);
        wait_idle(100);
        // Timeout, then a late op_done that must be ignored.
        @(posedge clk);
        add(0, 1'b1, 5'h11, 16'h0000, 20, 16'h1111, 1'b0, 0);
        wait_idle(100);
        repeat (8) @(negedge clk);
        // op_done coinciding with watchdog expiry.
        @(posedge clk);
        add(1, 1'b1, 5'h11, 16'h0000, TO - 1, 16'h0BAD, 1'b0, 0);
        wait_idle(100);
        // Write reporting no-ack, and a zero-latency completion.
        @(posedge clk);
        add(0, 1'b0, 5'h1F, 16'h0000, 2, 16'h5555, 1'b1, 0);
        wait_idle(100);
        @(posedge clk);
        add(1, 1'b0, 5'h10, 16'hBEEF, 0, 16'h0F0F, 1'b0, 0);
        wait_idle(100);
        // Reset during WAIT aborts silently.
        @(posedge clk);
        add(0, 1'b0, 5'h04, 16'h1234, -1, 16'h0000, 1'b0, 1);
        wait_idle(20);
        @(negedge clk);
        chk("busy_mid_op", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_async", 64'(outs), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("busy_after_abort", 64'(busy), 64'd0);
        // PRIO0=1: requester 0 held continuously starves requester 1.
        g0 = 0;
        g1 = 0;
        @(posedge clk);
        #1 p_req_valid = 2'b11;
        repeat (60) @(posedge clk);
        #1 p_req_valid = 2'b00;
        repeat (10) @(negedge clk);
        chk("prio_req1_grants", 64'(g1), 64'd0);
        chk("prio_req0_served", 64'(g0 >= 8), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
